// File: rtl/huff_l0_packer.sv
// Packs decoded Huffman symbols into row-wide L0 words, buffers them in a small
// word FIFO and drains that FIFO into the corelet L0 FIFO under l0_full backpressure.
module huff_l0_packer #(
   parameter int row   = 8,
   parameter int bw    = 4,
   parameter int depth = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [bw-1:0]       sym_in,
   input  logic                sym_valid,
   output logic                sym_ready,
   input  logic                flush,
   input  logic                l0_full,
   output logic                l0_wr,
   output logic [row*bw-1:0]   l0_data,
   output logic [15:0]         word_count,
   output logic                busy
);

   localparam int AW = (depth > 1) ? $clog2(depth) : 1;
   localparam int LW = (row > 1) ? $clog2(row) : 1;
   localparam int CW = $clog2(depth + 1);
   localparam int WW = row * bw;

   logic [WW-1:0] acc_q, acc_d;
   logic [LW-1:0] lane_q, lane_d;
   logic          flush_pend_q, flush_pend_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic          l0_wr_q, l0_wr_d;
   logic [WW-1:0] l0_data_q, l0_data_d;
   logic [15:0]   word_count_q, word_count_d;

   logic [WW-1:0] mem [depth];

   logic          fifo_full;
   logic          accept;
   logic          complete;
   logic          has_data;
   logic          pend_eff;
   logic          push;
   logic          pop;
   logic [WW-1:0] acc_ins;

   assign fifo_full = (fifo_cnt_q == CW'(depth));
   assign accept    = sym_valid && !fifo_full && !reset;
   assign complete  = accept && (lane_q == LW'(row - 1));
   assign has_data  = accept || (lane_q != '0);
   assign pend_eff  = flush_pend_q || flush;
   assign push      = complete || (pend_eff && !fifo_full && has_data);
   assign pop       = (fifo_cnt_q != '0) && !l0_full;

   // Current accumulator with this cycle's symbol already dropped into its lane,
   // so a coincident flush or completion pushes the symbol along with the word.
   genvar gi;
   generate
      for (gi = 0; gi < row; gi++) begin : g_lane
         assign acc_ins[gi*bw +: bw] = (accept && (lane_q == LW'(gi))) ?
                                       sym_in : acc_q[gi*bw +: bw];
      end
   endgenerate

   always_comb begin
      acc_d        = acc_ins;
      lane_d       = lane_q;
      flush_pend_d = flush_pend_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fifo_cnt_d   = fifo_cnt_q + CW'(push) - CW'(pop);
      l0_wr_d      = pop;
      l0_data_d    = l0_data_q;
      word_count_d = word_count_q;

      if (push) begin
         acc_d        = '0;
         lane_d       = '0;
         flush_pend_d = 1'b0;
         wr_ptr_d     = wr_ptr_q + AW'(1);
      end else begin
         if (accept) begin
            lane_d = lane_q + LW'(1);
         end
         // A pending flush only survives while there is data and no room for it.
         flush_pend_d = pend_eff && has_data;
      end

      if (pop) begin
         rd_ptr_d     = rd_ptr_q + AW'(1);
         l0_data_d    = mem[rd_ptr_q];
         word_count_d = word_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q        <= '0;
         lane_q       <= '0;
         flush_pend_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
         l0_wr_q      <= 1'b0;
         l0_data_q    <= '0;
         word_count_q <= '0;
      end else begin
         acc_q        <= acc_d;
         lane_q       <= lane_d;
         flush_pend_q <= flush_pend_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_cnt_q   <= fifo_cnt_d;
         l0_wr_q      <= l0_wr_d;
         l0_data_q    <= l0_data_d;
         word_count_q <= word_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr_q] <= acc_ins;
      end
   end

   assign sym_ready  = !reset && !fifo_full;
   assign l0_wr      = l0_wr_q && !reset;
   assign l0_data    = reset ? '0 : l0_data_q;
   assign word_count = reset ? 16'd0 : word_count_q;
   assign busy       = !reset && ((lane_q != '0) || (fifo_cnt_q != '0) ||
                                  l0_wr_q || flush_pend_q);

endmodule

// File: tb/tb_huff_l0_packer.sv
// Bench for huff_l0_packer: queue-based reference model checked every cycle,
// directed scenarios with literal word expectations, and a row=1 instance for counter wrap.
module tb_huff_l0_packer;

   localparam int ROW   = 8;
   localparam int BW    = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  sym_in = '0;
   logic        sym_valid = 1'b0;
   logic        sym_ready;
   logic        flush = 1'b0;
   logic        l0_full = 1'b0;
   logic        l0_wr;
   logic [31:0] l0_data;
   logic [15:0] word_count;
   logic        busy;

   logic        rst_w = 1'b1;
   logic        sym_valid_w = 1'b0;
   logic        sym_ready_w;
   logic        l0_wr_w;
   logic [3:0]  l0_data_w;
   logic [15:0] word_count_w;
   logic        busy_w;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   huff_l0_packer #(.row(ROW), .bw(BW), .depth(DEPTH)) u_dut (
      .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .flush(flush), .l0_full(l0_full), .l0_wr(l0_wr),
      .l0_data(l0_data), .word_count(word_count), .busy(busy)
   );

   huff_l0_packer #(.row(1), .bw(4), .depth(2)) u_wrap (
      .clk(clk), .reset(rst_w), .sym_in(4'h5), .sym_valid(sym_valid_w),
      .sym_ready(sym_ready_w), .flush(1'b0), .l0_full(1'b0), .l0_wr(l0_wr_w),
      .l0_data(l0_data_w), .word_count(word_count_w), .busy(busy_w)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model: queues of symbols and words ----------------
   logic [3:0]  cur[$];
   logic [31:0] mq[$];
   logic        m_pend = 1'b0;
   logic        m_wr = 1'b0;
   logic [31:0] m_data = '0;
   logic [15:0] m_cnt = '0;

   function automatic logic [31:0] pack(input logic [3:0] q[$]);
      logic [31:0] w = '0;
      for (int i = 0; i < q.size(); i++) w = w | (32'(q[i]) << (4 * i));
      return w;
   endfunction

   always @(posedge clk) begin
      int  sz;
      logic take;
      if (reset) begin
         cur.delete();
         mq.delete();
         m_pend = 1'b0;
         m_wr   = 1'b0;
         m_data = '0;
         m_cnt  = '0;
      end else begin
         sz   = mq.size();
         take = sym_valid && (sz < DEPTH);
         if (sz > 0 && !l0_full) begin
            m_wr   = 1'b1;
            m_data = mq.pop_front();
            m_cnt  = m_cnt + 16'd1;
         end else begin
            m_wr = 1'b0;
         end
         if (take) cur.push_back(sym_in);
         m_pend = m_pend || flush;
         if (cur.size() == ROW) begin
            mq.push_back(pack(cur));
            cur.delete();
            m_pend = 1'b0;
         end else if (m_pend) begin
            if (cur.size() == 0) begin
               m_pend = 1'b0;
            end else if (sz < DEPTH) begin
               mq.push_back(pack(cur));
               cur.delete();
               m_pend = 1'b0;
            end
         end
      end
   end

   logic [31:0] seen[$];

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_l0_wr", 32'(l0_wr), 32'd0);
         chk("rst_l0_data", l0_data, 32'd0);
         chk("rst_word_count", 32'(word_count), 32'd0);
         chk("rst_sym_ready", 32'(sym_ready), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end else begin
         chk("l0_wr", 32'(l0_wr), 32'(m_wr));
         if (m_wr) chk("l0_data", l0_data, m_data);
         chk("word_count", 32'(word_count), 32'(m_cnt));
         chk("sym_ready", 32'(sym_ready), 32'(mq.size() < DEPTH));
         chk("busy", 32'(busy), 32'((cur.size() != 0) || (mq.size() != 0) || m_wr || m_pend));
         if (l0_wr) begin
            seen.push_back(l0_data);
            $display("l0 write data=%h word_count=%0d", l0_data, word_count);
         end
      end
   end

   // ---------------- counter wrap instance ----------------
   int  wcnt = 0;
   logic wrap_done = 1'b0;

   always @(negedge clk) begin
      if (!rst_w && l0_wr_w) begin
         wcnt++;
         chk("wrap_count", 32'(word_count_w), 32'(wcnt % 65536));
         if (wcnt == 65536) chk("wrap_zero", 32'(word_count_w), 32'd0);
      end
   end

   initial begin
      int n = 0;
      repeat (3) @(posedge clk);
      #1 rst_w = 1'b0;
      sym_valid_w = 1'b1;
      while (wcnt < 65540 && n < 70000) begin
         @(posedge clk);
         n++;
      end
      if (wcnt < 65540) begin
         total++;
         bad++;
         $display("FAIL wrap_timeout: got %0d words expected 65540", wcnt);
      end
      #1 sym_valid_w = 1'b0;
      wrap_done = 1'b1;
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      l0_full = 1'b0;
      seen.delete();
   endtask

   task automatic send(input logic [3:0] s, input logic f);
      int tmo = 0;
      sym_in = s;
      sym_valid = 1'b1;
      flush = f;
      forever begin
         @(negedge clk);
         if (sym_ready) break;
         tmo++;
         if (tmo > 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got sym_ready=0 expected 1");
            break;
         end
      end
      @(posedge clk);
      #1;
      sym_valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
   endtask

   initial begin
      cyc(3);

      // basic word
      do_reset();
      for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
      cyc(4);
      chk("basic_count", 32'(seen.size()), 32'd1);
      chk("basic_data", seen[0], 32'h87654321);
      chk("basic_wc", 32'(word_count), 32'd1);
      chk("basic_busy", 32'(busy), 32'd0);

      // backpressure
      do_reset();
      l0_full = 1'b1;
      for (int i = 0; i < 32; i++) send(4'(i), 1'b0);
      cyc(2);
      chk("bp_ready_low", 32'(sym_ready), 32'd0);
      chk("bp_no_write", 32'(seen.size()), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      l0_full = 1'b0;
      for (int i = 32; i < 40; i++) send(4'(i), 1'b0);
      cyc(8);
      chk("bp_words", 32'(seen.size()), 32'd5);
      chk("bp_w0", seen[0], 32'h76543210);
      chk("bp_w1", seen[1], 32'hFEDCBA98);
      chk("bp_w4", seen[4], 32'h76543210);
      chk("bp_wc", 32'(word_count), 32'd5);

      // flush partial, then flush with empty lane
      do_reset();
      send(4'hA, 1'b0);
      send(4'hB, 1'b0);
      send(4'hC, 1'b0);
      pulse_flush();
      cyc(4);
      chk("fl_count", 32'(seen.size()), 32'd1);
      chk("fl_data", seen[0], 32'h00000CBA);
      chk("fl_wc", 32'(word_count), 32'd1);
      pulse_flush();
      cyc(4);
      chk("fl_empty_count", 32'(seen.size()), 32'd1);
      chk("fl_empty_wc", 32'(word_count), 32'd1);
      chk("fl_empty_busy", 32'(busy), 32'd0);

      // flush coincident with the completing symbol
      do_reset();
      for (int i = 1; i <= 7; i++) send(4'(i), 1'b0);
      send(4'h8, 1'b1);
      cyc(4);
      chk("co_count", 32'(seen.size()), 32'd1);
      chk("co_data", seen[0], 32'h87654321);

      // flush coincident with a mid-word symbol
      send(4'h3, 1'b0);
      send(4'h9, 1'b1);
      cyc(4);
      chk("co_part_data", seen[1], 32'h00000093);
      chk("co_part_wc", 32'(word_count), 32'd2);

      // reset mid-operation
      do_reset();
      l0_full = 1'b1;
      for (int i = 0; i < 21; i++) send(4'(i), 1'b0);
      cyc(2);
      chk("rm_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      l0_full = 1'b0;
      cyc(1);
      reset = 1'b0;
      cyc(4);
      chk("rm_no_write", 32'(seen.size()), 32'd0);
      chk("rm_wc", 32'(word_count), 32'd0);
      chk("rm_busy", 32'(busy), 32'd0);
      for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
      cyc(4);
      chk("rm_clean_data", seen[0], 32'h87654321);
      chk("rm_clean_wc", 32'(word_count), 32'd1);

      while (!wrap_done) @(posedge clk);
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/huff_l0_packer.md
# huff_l0_packer

Downstream stage of the Huffman decoder in `core`. It collects the 4-bit activation symbols the decoder emits into full row-wide L0 words, buffers them in a small word FIFO, and writes them into the corelet L0 FIFO using `l0_wr`/`l0_data`. When the decoder path is selected, this block replaces the direct `decodedData`/`decodedData_valid` connection to L0. It applies backpressure to the decoder whenever its word buffer cannot accept more data.

## Interface
- `row`, default 8: symbols per L0 word (number of array rows).
- `bw`, default 4: symbol width in bits.
- `depth`, default 4: word FIFO depth; must be a power of 2, ≥2.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `sym_in` in bw: decoded symbol.
- `sym_valid` in 1: `sym_in` is valid this cycle.
- `sym_ready` out 1: block can accept a symbol this cycle.
- `flush` in 1: one-cycle pulse; emit the partial word, zero-padded.
- `l0_full` in 1: L0 cannot accept a write this cycle.
- `l0_wr` out 1: L0 write strobe (registered).
- `l0_data` out row*bw: L0 write data (registered).
- `word_count` out 16: number of words written to L0; wraps.
- `busy` out 1: data is held anywhere in the block.

## Operation
**Accept rule**
- A symbol is accepted when `sym_valid && sym_ready`.
- `sym_ready = !reset && (fifo_cnt < depth)`.

**Accumulator**
- The accumulator is `acc` (row*bw bits) with a lane counter `lane` (0..row-1).
- An accepted symbol is written to lane `lane`, bits `[bw*lane+bw-1 : bw*lane]`.
- Lane 0 is the first symbol and maps to L0 row 0.

**Word completion**
- A word completes when a symbol is accepted with `lane == row-1`.
- On completion, the word is pushed into the FIFO, `lane` is set to 0, and `acc` is cleared.

**Flush**
- A `flush` pulse sets `flush_pend`.
- While `flush_pend` is set, `lane != 0`, and the FIFO is not full, the following happen at the same edge:
  - the partial word is pushed, with unfilled lanes set to 0;
  - `lane` is set to 0 and `acc` is cleared;
  - `flush_pend` is cleared.
- If `lane == 0` and no symbol is accepted that cycle, `flush_pend` clears with no push.
- If a symbol is accepted in the same cycle as `flush`, the symbol is included in the flushed word.
- If that symbol completes the word, only one push occurs and `flush_pend` clears.
- `sym_ready` stays high during `flush_pend` when the FIFO has space. A symbol accepted while the flush is still pending joins the flushed word.

**FIFO**
- Circular buffer with read and write pointers of log2(depth) bits, which wrap.
- Occupancy `fifo_cnt` runs from 0 to depth.
- Push and pop in the same cycle leave `fifo_cnt` unchanged.
- A push is never attempted when the FIFO is full; `sym_ready` guarantees this.

**Drain**
- At each edge, if `fifo_cnt > 0` and `l0_full == 0`: pop the head into `l0_data`, set `l0_wr = 1`, and increment `word_count` modulo 2^16.
- Otherwise `l0_wr = 0` and `l0_data` holds its last value.

**Busy**
- `busy = (lane != 0) | (fifo_cnt != 0) | l0_wr | flush_pend`.

**Reset**
- Clears `acc`, `lane`, the pointers, `fifo_cnt`, and `flush_pend`.
- Outputs while reset is asserted: `l0_wr=0`, `l0_data=0`, `word_count=0`, `busy=0`, `sym_ready=0`.
- Reset asserted mid-word discards the partial word and any buffered words; nothing is written to L0.

## Timing
- The last symbol of a word is accepted at edge N, and the word enters the FIFO at edge N. If the FIFO was empty and `l0_full` is low at edge N+1, `l0_wr` is high for the cycle after N+1.
- Minimum latency from the last symbol to `l0_wr` is therefore 1 cycle.
- `l0_full` is sampled at the clock edge. A word is never written while `l0_full` was high at the sampling edge.
- Sustained throughput is 1 symbol/cycle in and 1 word per `row` cycles out. Back-to-back `l0_wr` pulses are allowed.
- `sym_ready` is combinational from `fifo_cnt`. It drops in the cycle after the push that fills the FIFO.
- A flush push occurs at the first edge where `flush_pend` is set and the FIFO has space. With an empty FIFO this is the edge that samples `flush`.
- `word_count` updates at the same edge that raises `l0_wr`.

## Test plan
- **Basic word:** feed symbols 1,2,…,8 on consecutive cycles with `l0_full=0` → a single `l0_wr` pulse with `l0_data=0x87654321`, `word_count=1`, and `busy` low afterwards.
- **Backpressure:** stream 40 symbols with `l0_full=1` → 4 words buffered and `sym_ready=0` after the 32nd symbol. Release `l0_full` → 4 consecutive `l0_wr` pulses in order, `sym_ready` reasserts, and all 5 words (40 symbols) are eventually written in order.
- **Flush partial:** symbols A,B,C, then a `flush` pulse → `l0_data=0x00000CBA`, `word_count=1`. A flush with `lane==0` produces no write.
- **Flush with coincident symbol:** 7 symbols, then the 8th together with `flush` → exactly one word with all 8 lanes and no extra zero word.
- **Reset mid-operation:** 5 symbols accepted and 2 words held under `l0_full=1`, then reset for 1 cycle → no `l0_wr`, `word_count=0`, `busy=0`. The next 8 symbols form a clean word.
- **Counter wrap:** preload by streaming 65536 words → `word_count` wraps to 0 on the 65536th write.
